// File: rtl/memory_rstl_max_n_pkg.sv
// Shared types and helpers for the ping-pong CNN result memory.
package cnn_mem_pkg;

  // Selects one of the two ping-pong banks.
  typedef logic bank_t;

  // Signed add that clamps the result to the range of a w-bit two's
  // complement number. The result comes back sign-extended to 32 bits, so
  // callers keep only the low w bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    sum   = a + b;
    max_v = 32'sh7fff_ffff >>> (32 - w);
    min_v = -max_v - 32'sd1;
    if (sum > max_v) begin
      return max_v;
    end
    if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/memory_rstl_max_n_bank_ram.sv
// One ping-pong bank: LANES write ports and a single registered read port.
module rstl_bank_ram
  import cnn_mem_pkg::*;
#(
  parameter int LANES  = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 507,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [LANES-1:0]         wr_mask,
  input  logic [LANES*ADDR_W-1:0]  wr_addr,
  input  logic [LANES*DATA_W-1:0]  wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx [LANES];
  logic [LANES-1:0]  wr_ok;
  logic              rd_ok;

  // Split the packed lane addresses and flag the lanes that land inside the bank.
  always_comb begin
    logic [ADDR_W-1:0] lane_addr;
    lane_addr = '0;
    wr_ok     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr = wr_addr[i*ADDR_W +: ADDR_W];
      wr_ok[i]  = ({1'b0, lane_addr} < DEPTH_L);
      wr_idx[i] = lane_addr[IDX_W-1:0];
    end
  end

  assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);

  // Lane writes in ascending order so the highest lane wins an address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && wr_mask[i] && wr_ok[i]) begin
        mem[wr_idx[i]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read; out-of-range reads leave the register alone.
  always_ff @(posedge clk) begin
    if (rd_en && rd_ok) begin
      rd_q <= mem[rd_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/memory_rstl_max_n.sv
// Ping-pong result memory between max-pool and the next CNN layer:
// bank swap control, read mux and saturating read offset.
module memory_rstl_max_n
  import cnn_mem_pkg::*;
#(
  parameter int LANES  = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 507,
  parameter int ADDR_W = 10,
  parameter int OFFSET = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [LANES-1:0]         wr_lane_mask,
  input  logic [LANES*ADDR_W-1:0]  wr_addr,
  input  logic [LANES*DATA_W-1:0]  wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic                     rd_avail,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_release,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     err_oob
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  bank_t             wb;
  bank_t             rb;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_fire;
  logic              commit;
  logic              rd_fire;
  logic              rel_fire;
  logic              lane_oob;
  logic              rd_oob;
  logic              err_nxt;
  logic              rd_oob_q;
  bank_t             rd_bank_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] ram_q [2];
  logic [DATA_W-1:0] sat_val;

  assign wr_ready = !full[wb];
  assign rd_avail = full[rb];
  assign wr_fire  = wr_en && wr_ready;
  assign commit   = wr_fire && wr_last;
  assign rd_fire  = rd_en && rd_avail;
  assign rel_fire = rd_release && rd_avail;
  assign rd_oob   = ({1'b0, rd_addr} >= DEPTH_L);

  // Any enabled lane pointing past the end of the bank is an error.
  always_comb begin
    lane_oob = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane_mask[i] && ({1'b0, wr_addr[i*ADDR_W +: ADDR_W]} >= DEPTH_L)) begin
        lane_oob = 1'b1;
      end
    end
  end

  assign err_nxt = (wr_en && !wr_ready) || (wr_fire && lane_oob) ||
                   (rd_fire && rd_oob) || (rd_en && !rd_avail) ||
                   (rd_release && !rd_avail);

  // Commit and release always hit different banks, so both can apply at once.
  always_comb begin
    full_nxt = full;
    if (commit) begin
      full_nxt[wb] = 1'b1;
    end
    if (rel_fire) begin
      full_nxt[rb] = 1'b0;
    end
  end

  // Bank ownership state; a reset throws away both partial and committed frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb   <= 1'b0;
      rb   <= 1'b0;
      full <= 2'b00;
    end else begin
      full <= full_nxt;
      if (commit) begin
        wb <= ~wb;
      end
      if (rel_fire) begin
        rb <= ~rb;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_bank
    rstl_bank_ram #(
      .LANES (LANES),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk    (clk),
      .wr_en  (wr_fire && (wb == bank_t'(k))),
      .wr_mask(wr_lane_mask),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_en  (rd_fire && (rb == bank_t'(k))),
      .rd_addr(rd_addr),
      .rd_q   (ram_q[k])
    );
  end

  // Remember which bank answered, so a same-cycle release cannot redirect the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_oob_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_oob_q <= rd_fire && rd_oob;
      err_oob  <= err_nxt;
      if (rd_fire) begin
        rd_bank_q <= rb;
      end
    end
  end

  assign sat_val = DATA_W'(sat_add(32'($signed(ram_q[rd_bank_q])), OFFSET, DATA_W));

  // Read data is zero for out-of-range reads and holds its last value when idle.
  always_comb begin
    rd_data = hold_q;
    if (rd_valid) begin
      rd_data = rd_oob_q ? '0 : sat_val;
    end
  end

  // Capture the value presented so it can be held on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (rd_valid) begin
      hold_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_memory_rstl_max_n.sv
// Directed table-driven bench; runs OFFSET=0 and OFFSET=10 copies side by side.
module tb_memory_rstl_max_n;

  localparam int LANES  = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 507;
  localparam int ADDR_W = 10;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    wr_en;
  logic [LANES-1:0]        wr_lane_mask;
  logic [LANES*ADDR_W-1:0] wr_addr;
  logic [LANES*DATA_W-1:0] wr_data;
  logic                    wr_last;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_release;

  logic                     wr_ready0, rd_avail0, rd_valid0, err_oob0;
  logic signed [DATA_W-1:0] rd_data0;
  logic                     wr_ready10, rd_avail10, rd_valid10, err_oob10;
  logic signed [DATA_W-1:0] rd_data10;

  int checks   = 0;
  int failures = 0;
  int hold0    = 0;
  int hold10   = 0;

  typedef struct {
    logic       we;
    logic       last;
    logic [2:0] mask;
    int         a0, a1, a2;
    int         d0, d1, d2;
    logic       re;
    int         raddr;
    logic       rel;
    logic       x_ready;
    logic       x_avail;
    logic       x_err;
    logic       x_valid;
    logic       x_oob;
    int         raw;
  } vec_t;

  vec_t vecs [21];
  vec_t idle;
  vec_t cur;

  memory_rstl_max_n #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .ADDR_W(ADDR_W), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_lane_mask(wr_lane_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready0), .rd_avail(rd_avail0), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_release(rd_release), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .err_oob(err_oob0)
  );

  memory_rstl_max_n #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .ADDR_W(ADDR_W), .OFFSET(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_lane_mask(wr_lane_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready10), .rd_avail(rd_avail10), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_release(rd_release), .rd_data(rd_data10),
    .rd_valid(rd_valid10), .err_oob(err_oob10)
  );

  always #5 clk = ~clk;

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en        = v.we;
    wr_last      = v.last;
    wr_lane_mask = v.mask;
    wr_addr      = {ADDR_W'(v.a2), ADDR_W'(v.a1), ADDR_W'(v.a0)};
    wr_data      = {DATA_W'(v.d2), DATA_W'(v.d1), DATA_W'(v.d0)};
    rd_en        = v.re;
    rd_addr      = ADDR_W'(v.raddr);
    rd_release   = v.rel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic x_ready, input logic x_avail,
                          input logic x_err, input logic x_valid, input int e0,
                          input int e10);
    checkOutput({tag, ".wr_ready"},  {31'b0, wr_ready0},  {31'b0, x_ready});
    checkOutput({tag, ".rd_avail"},  {31'b0, rd_avail0},  {31'b0, x_avail});
    checkOutput({tag, ".err_oob"},   {31'b0, err_oob0},   {31'b0, x_err});
    checkOutput({tag, ".rd_valid"},  {31'b0, rd_valid0},  {31'b0, x_valid});
    checkOutput({tag, ".rd_data"},   32'($signed(rd_data0)), e0);
    checkOutput({tag, ".wr_ready10"}, {31'b0, wr_ready10}, {31'b0, x_ready});
    checkOutput({tag, ".rd_avail10"}, {31'b0, rd_avail10}, {31'b0, x_avail});
    checkOutput({tag, ".err_oob10"},  {31'b0, err_oob10},  {31'b0, x_err});
    checkOutput({tag, ".rd_valid10"}, {31'b0, rd_valid10}, {31'b0, x_valid});
    checkOutput({tag, ".rd_data10"},  32'($signed(rd_data10)), e10);
  endtask

  initial begin
    int e0;
    int e10;

    idle = '{default: 0};
    applyStimulus(idle);
    rst_n = 1'b0;
    #2;
    checkAll("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checkAll("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    //         we    last  mask    a0 a1  a2  d0    d1  d2   re    raddr rel   rdy   avl   err   vld   oob   raw
    vecs[0]  = '{1'b1, 1'b1, 3'b111, 0, 1,   2, 5,   -3, 127, 1'b0, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5};
    vecs[2]  = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -3};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 2,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 127};
    vecs[4]  = '{1'b1, 1'b0, 3'b111, 3, 600, 4, -128, 55, 20,  1'b0, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 3'b101, 7, 0,   7, 1,    0,   9,  1'b0, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b1, 3'b111, 0, 1,   2, 1,    1,   1,  1'b0, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5};
    vecs[8]  = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 507, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    vecs[9]  = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -3};
    vecs[10] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b0, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 127};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 3,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -128};
    vecs[13] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 7,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9};
    vecs[14] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 4,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20};
    vecs[15] = '{1'b1, 1'b1, 3'b001, 10, 0,  0, -7,   0,   0,  1'b0, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[16] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 10,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -7};
    vecs[17] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b0, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[18] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[19] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b0, 0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[20] = '{1'b0, 1'b0, 3'b000, 0, 0,   0, 0,    0,   0, 1'b0, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      step();
      if (vecs[i].x_valid) begin
        e0     = vecs[i].x_oob ? 0 : vecs[i].raw;
        e10    = vecs[i].x_oob ? 0 : clamp8(vecs[i].raw + 10);
        hold0  = e0;
        hold10 = e10;
      end else begin
        e0  = hold0;
        e10 = hold10;
      end
      checkAll($sformatf("v%0d", i), vecs[i].x_ready, vecs[i].x_avail, vecs[i].x_err,
               vecs[i].x_valid, e0, e10);
    end

    // Commit one frame, then start a second frame and reset partway through it.
    cur = idle;
    cur.we = 1'b1; cur.last = 1'b1; cur.mask = 3'b111;
    cur.a0 = 0; cur.a1 = 1; cur.a2 = 2;
    cur.d0 = 11; cur.d1 = 12; cur.d2 = 13;
    applyStimulus(cur);
    step();
    checkAll("frameA", 1'b1, 1'b1, 1'b0, 1'b0, hold0, hold10);

    for (int k = 0; k < 4; k++) begin
      cur = idle;
      cur.we = 1'b1; cur.mask = 3'b001; cur.a0 = 20 + k; cur.d0 = k;
      cur.re = (k == 3); cur.raddr = 0;
      applyStimulus(cur);
      step();
    end
    checkAll("partial", 1'b1, 1'b1, 1'b0, 1'b1, 11, 21);

    applyStimulus(idle);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checkAll("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_rstl_max_n.md
Name: memory_rstl_max_n

Overview:
Double-buffered (ping-pong) result memory between a max-pool stage and the next CNN layer. Accepts LANES parallel pooled results per cycle into a write bank while the consumer reads the other bank. A frame commit/release handshake swaps the banks. The read path applies a signed, saturating offset.

Parameters:
LANES, 3, number of parallel write lanes
DATA_W, 8, signed data width per element
DEPTH, 507, elements per bank
ADDR_W, 10, address width; must satisfy 2**ADDR_W >= DEPTH
OFFSET, 0, signed constant added to read data, saturated to DATA_W

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe for all lanes enabled in wr_lane_mask
wr_lane_mask  in  LANES  per-lane write enable, qualified by wr_en
wr_addr  in  LANES*ADDR_W  packed lane addresses; lane i at [i*ADDR_W +: ADDR_W]
wr_data  in  LANES*DATA_W  packed signed lane data
wr_last  in  1  with wr_en, commits the current write bank after this cycle's writes
wr_ready  out  1  write bank is free (not full)
rd_avail  out  1  read bank holds a committed frame
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_release  in  1  consumer done; frees the read bank
rd_data  out  DATA_W  signed read data, offset applied
rd_valid  out  1  rd_data valid this cycle
err_oob  out  1  one-cycle pulse on an out-of-range or illegal access

Behaviour:
- State: wb (write bank index), rb (read bank index), full[1:0].
- Reset (async assert, sync release): wb=0, rb=0, full=0, rd_data=0, rd_valid=0, err_oob=0. Memory contents are not reset. A reset mid-frame discards the partial frame and any committed frame.
- wr_ready = !full[wb]; rd_avail = full[rb]; both combinational from state.
- Write (wr_en & wr_ready): each lane with mask bit set and addr < DEPTH writes bank wb on the same edge.
  - Lane addr >= DEPTH: that lane is dropped, other lanes still write, err_oob=1 next cycle.
  - Several lanes at the same address: the highest lane index wins.
- wr_en while !wr_ready: no write occurs, err_oob=1 next cycle, wr_last is ignored.
- Commit (wr_en & wr_last & wr_ready): full[wb]<=1 and wb toggles on the same edge.
- Read (rd_en & rd_avail): rd_valid=1 and rd_data=sat(mem[rb][rd_addr]+OFFSET) on the next edge, i.e. latency 1.
  - rd_addr >= DEPTH: rd_data=0, rd_valid=1, err_oob=1.
  - rd_en & !rd_avail: rd_valid=0, rd_data holds its value, err_oob=1.
  - Otherwise rd_valid=0 and rd_data holds.
- Saturation: compute the sum in DATA_W+1 bits and clamp to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- Release (rd_release & rd_avail): full[rb]<=0 and rb toggles. rd_release & !rd_avail: ignored, err_oob=1.
- rd_en together with rd_release: the read uses the old rb, and the data is still returned next cycle.
- Commit and release in the same cycle: both take effect. They cannot target the same bank, because commit needs !full and release needs full.
- err_oob is the OR of all error causes in a cycle and is never sticky.
- Both banks full: wr_ready=0 until a release. Both banks empty: rd_avail=0.

Decomposition:
- Package cnn_mem_pkg: sat_add function and the bank-index typedef.
- One sub-module, rstl_bank_ram: a single bank with LANES write ports and 1 registered read port, instantiated twice.
- Top level holds the bank-control state, the read mux and the offset/saturation logic.

Test Plan:
- Reset, then write lanes {0:5, 1:-3, 2:127} at addresses {0,1,2} with wr_last; read addresses 0..2 with OFFSET=0 -> rd_data 5, -3, 127, each one cycle after rd_en; rd_avail=1.
- OFFSET=10, stored values 127 and -128 -> reads return 127 (saturated) and -118.
- Commit two frames with no release -> wr_ready=0. A further wr_en -> err_oob pulse and memory unchanged. rd_release -> wr_ready=1 and rd_avail stays 1 (second frame).
- Lanes 0 and 2 both target address 7 with data 1 and 9 -> reading address 7 returns 9. Lane 1 at address 600 -> dropped, err_oob=1.
- rd_en at address 507 -> rd_data=0, rd_valid=1, err_oob=1. rd_en with rd_avail=0 -> rd_valid=0 and err_oob=1.
- Assert rst_n low mid-frame after 4 writes -> wr_ready=1, rd_avail=0, rd_valid=0 immediately, without waiting for a clock edge.
